operand_fetch_stage: RTL

- Upstream neighbour of the ALU: owns the 32-entry integer register file and selects operands.
- Presents registered SrcA, SrcB and ALUControl to the ALU through a single-entry valid/ready output register.
- Accepts one writeback per cycle from the result path.
- Write-to-read bypass lets a result written in the same cycle as an operand read be seen by that read.

---
 rtl/operand_fetch_stage.sv | 83 ++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch: 32-entry integer register file with write-to-read bypass,
// feeding the ALU through a single-entry valid/ready output register.
module operand_fetch_stage #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      Rs1,
   input  logic [4:0]      Rs2,
   input  logic [4:0]      Rd,
   input  logic [XLEN-1:0] ImmExt,
   input  logic            ALUSrc,
   input  logic [2:0]      ALUControlIn,
   input  logic            WE3,
   input  logic [4:0]      A3,
   input  logic [XLEN-1:0] WD3,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] SrcA,
   output logic [XLEN-1:0] SrcB,
   output logic [XLEN-1:0] WriteData,
   output logic [2:0]      ALUControl,
   output logic [4:0]      RdOut
);

   logic [XLEN-1:0] regs [NREG];
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            accept;

   // x0 is hardwired; a same-cycle writeback wins over the stored value
   function automatic logic [XLEN-1:0] read_reg(input logic [4:0] r);
      logic [XLEN-1:0] v;
      if (r == 5'd0)
         v = '0;
      else if (WE3 && A3 == r)
         v = WD3;
      else
         v = regs[r];
      return v;
   endfunction

   always_comb begin
      rs1_val = read_reg(Rs1);
      rs2_val = read_reg(Rs2);
   end

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (WE3 && A3 != 5'd0) begin
         regs[A3] <= WD3;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         SrcA       <= '0;
         SrcB       <= '0;
         WriteData  <= '0;
         ALUControl <= 3'b000;
         RdOut      <= 5'd0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         SrcA       <= rs1_val;
         SrcB       <= ALUSrc ? ImmExt : rs2_val;
         WriteData  <= rs2_val;
         ALUControl <= ALUControlIn;
         RdOut      <= Rd;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule
